// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the board clock divider controller.
package clk_div_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOPPING = 2'd2} state_t;
  localparam int CNT_W_D    = 26;
  localparam int DEF_HALF_D = 25_000_000;
  localparam int BURST_W_D  = 8;
endpackage

// File: rtl/div_counter.sv
// Half-period counter: counts active enabled cycles, ticks on terminal count, reloads to 0.
module div_counter #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] half,
  output logic             tick
);
  logic [CNT_W-1:0] cnt;

  assign tick = active & en & (cnt == half - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (clr || tick)   cnt <= '0;
    else if (active && en)  cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the board clock divider: start/stop sequencing, burst mode,
// and glitch-free half-period updates applied only at half-period boundaries.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_D,
  parameter int DEF_HALF = DEF_HALF_D,
  parameter int BURST_W  = BURST_W_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_half,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               clk_out,
  output logic               tick,
  output logic               busy,
  output logic               done
);
  state_t             state, state_n;
  logic [CNT_W-1:0]   half_r, pend_half, cfg_clamped;
  logic               pend_valid;
  logic [BURST_W-1:0] burst_r, rem;
  logic               start_ok, park_low, last, cfg_fire, clr;

  assign cfg_clamped = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
  assign cfg_ready   = !pend_valid;
  assign cfg_fire    = cfg_valid & cfg_ready;
  assign busy        = (state != IDLE);
  assign start_ok    = (state == IDLE) & start & !stop;
  // Stopping with the output already low: leave on the next cycle without toggling.
  assign park_low    = (state == STOPPING) & !clk_out;
  assign last        = (state == RUN) & tick & clk_out & (burst_r != '0) & (rem == BURST_W'(1));
  assign done        = last;
  assign clr         = start_ok | park_low;

  div_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .active (busy),
    .en     (en),
    .clr    (clr),
    .half   (half_r),
    .tick   (tick)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (start_ok) state_n = RUN;
      RUN: begin
        if (last)                          state_n = IDLE;
        else if (stop && tick && clk_out)  state_n = IDLE;
        else if (stop)                     state_n = STOPPING;
      end
      STOPPING: if (!clk_out || tick) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_out <= 1'b0;
      burst_r <= '0;
      rem     <= '0;
    end else if (start_ok) begin
      clk_out <= 1'b0;
      burst_r <= cfg_burst;
      rem     <= cfg_burst;
    end else if (tick && !park_low) begin
      clk_out <= ~clk_out;
      if (state == RUN && clk_out && rem != '0) rem <= rem - BURST_W'(1);
    end
  end

  // While generating, new half-periods wait in pend_half until a tick so the
  // running compare never sees a value change mid-period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_r     <= CNT_W'(DEF_HALF);
      pend_half  <= '0;
      pend_valid <= 1'b0;
    end else if (state == IDLE) begin
      if (pend_valid) begin
        half_r     <= pend_half;
        pend_valid <= 1'b0;
      end else if (cfg_fire) begin
        half_r <= cfg_clamped;
      end
    end else begin
      if (tick && pend_valid) begin
        half_r     <= pend_half;
        pend_valid <= 1'b0;
      end
      if (cfg_fire) begin
        pend_half  <= cfg_clamped;
        pend_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus randomized runs
// checked against an arithmetic model (enabled-cycle count vs. half-period).
module tb_clk_div_ctrl;
  localparam int CNT_W = 8, DEF_HALF = 5, BURST_W = 4;

  logic clk = 1'b0, rst = 1'b1, en = 1'b1, cfg_valid = 1'b0, start = 1'b0, stop = 1'b0;
  logic [CNT_W-1:0]   cfg_half  = '0;
  logic [BURST_W-1:0] cfg_burst = '0;
  logic cfg_ready, clk_out, tick, busy, done;
  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  clk_div_ctrl #(.CNT_W(CNT_W), .DEF_HALF(DEF_HALF), .BURST_W(BURST_W)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_half(cfg_half), .cfg_burst(cfg_burst), .start(start), .stop(stop),
    .clk_out(clk_out), .tick(tick), .busy(busy), .done(done)
  );

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic clk_edge();
    @(posedge clk); #1;
  endtask

  task automatic launch(input int h, input int n);
    clk_edge();
    cfg_half = CNT_W'(h); cfg_valid = 1'b1;
    clk_edge();
    cfg_valid = 1'b0; cfg_burst = BURST_W'(n); start = 1'b1;
    clk_edge();
    start = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0; stop = 1'b1;
    clk_edge();
    stop = 1'b0;
    for (int i = 0; i < 100; i++) begin
      settle();
      if (!busy) begin ok = 1'b1; break; end
      clk_edge();
    end
    clk_edge();
  endtask

  task automatic test_reset();
    int first;
    rst = 1'b1;
    repeat (2) clk_edge();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      settle();
      total_cnt++;
      if ({clk_out, tick, busy, done} !== 4'b0000) $display("FAIL reset_idle: got %b want 0000", {clk_out, tick, busy, done});
      else pass_cnt++;
      total_cnt++;
      if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready);
      else pass_cnt++;
      clk_edge();
    end
    // No cfg since reset: first tick spacing exposes the default half-period.
    first = 0;
    cfg_burst = BURST_W'(1); start = 1'b1;
    clk_edge();
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      settle();
      if (tick && first == 0) first = k;
      clk_edge();
    end
    total_cnt++;
    if (first !== DEF_HALF) $display("FAIL reset_def_half: first tick cycle %0d want %0d", first, DEF_HALF);
    else pass_cnt++;
    settle();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_burst_end: busy %b want 0", busy);
    else pass_cnt++;
    clk_edge();
  endtask

  task automatic test_continuous();
    int first; bit ok; logic [2:0] exp;
    first = 0;
    launch(3, 0);
    for (int k = 1; k <= 24; k++) begin
      settle();
      exp = {(((k - 1) / 3) % 2) == 1, ((k - 1) % 3) == 2, 1'b0};
      total_cnt++;
      if ({clk_out, tick, done} !== exp) $display("FAIL cont_wave k=%0d: got %b want %b", k, {clk_out, tick, done}, exp);
      else pass_cnt++;
      if (tick && first == 0) first = k;
      clk_edge();
    end
    total_cnt++;
    if (first !== 3) $display("FAIL cont_first_tick: got %0d want 3", first);
    else pass_cnt++;
    drain(ok);
    total_cnt++;
    if (!ok) $display("FAIL cont_drain: still busy after stop");
    else pass_cnt++;
  endtask

  task automatic test_burst();
    int pulses, hlen, bad_len, done_cnt, done_k; logic prev, b12, b13;
    pulses = 0; hlen = 0; bad_len = 0; done_cnt = 0; done_k = 0; prev = 1'b0; b12 = 1'bx; b13 = 1'bx;
    launch(2, 3);
    for (int k = 1; k <= 30; k++) begin
      settle();
      if (clk_out) hlen++;
      if (prev && !clk_out) begin if (hlen != 2) bad_len++; hlen = 0; end
      if (!prev && clk_out) pulses++;
      prev = clk_out;
      if (done) begin done_cnt++; done_k = k; end
      if (k == 12) b12 = busy;
      if (k == 13) b13 = busy;
      clk_edge();
    end
    total_cnt++;
    if (pulses !== 3) $display("FAIL burst_pulses: got %0d want 3", pulses); else pass_cnt++;
    total_cnt++;
    if (bad_len !== 0) $display("FAIL burst_high_len: %0d pulses not 2 cycles", bad_len); else pass_cnt++;
    total_cnt++;
    if (done_cnt !== 1 || done_k !== 12) $display("FAIL burst_done: count %0d at %0d want 1 at 12", done_cnt, done_k); else pass_cnt++;
    total_cnt++;
    if ({b12, b13} !== 2'b10) $display("FAIL burst_busy_drop: got %b want 10", {b12, b13}); else pass_cnt++;
  endtask

  task automatic test_cfg_mid();
    bit ok; logic [2:0] exp;
    launch(4, 0);
    for (int k = 1; k <= 10; k++) begin
      cfg_valid = (k == 2); cfg_half = CNT_W'(1);
      settle();
      exp = {!(k == 3 || k == 4), k >= 4, k >= 5 && ((k - 5) % 2) == 0};
      total_cnt++;
      if ({cfg_ready, tick, clk_out} !== exp) $display("FAIL cfg_mid k=%0d: ready/tick/out %b want %b", k, {cfg_ready, tick, clk_out}, exp);
      else pass_cnt++;
      clk_edge();
    end
    cfg_valid = 1'b0;
    drain(ok);
    total_cnt++;
    if (!ok) $display("FAIL cfg_mid_drain: still busy after stop"); else pass_cnt++;
  endtask

  task automatic test_stop();
    logic [2:0] exp;
    launch(5, 0);
    for (int k = 1; k <= 12; k++) begin
      stop = (k == 7);
      settle();
      exp = {k >= 6 && k <= 10, k <= 10, k == 5 || k == 10};
      total_cnt++;
      if ({clk_out, busy, tick} !== exp) $display("FAIL stop_high k=%0d: out/busy/tick %b want %b", k, {clk_out, busy, tick}, exp);
      else pass_cnt++;
      clk_edge();
    end
    stop = 1'b0;
    start = 1'b1; stop = 1'b1;
    clk_edge();
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      total_cnt++;
      if ({busy, clk_out} !== 2'b00) $display("FAIL start_stop_idle: busy/out %b want 00", {busy, clk_out});
      else pass_cnt++;
      clk_edge();
    end
    launch(5, 0);
    for (int k = 1; k <= 5; k++) begin
      stop = (k == 3);
      settle();
      exp = {1'b0, k <= 4, 1'b0};
      total_cnt++;
      if ({clk_out, busy, tick} !== exp) $display("FAIL stop_low k=%0d: out/busy/tick %b want %b", k, {clk_out, busy, tick}, exp);
      else pass_cnt++;
      clk_edge();
    end
    stop = 1'b0;
  endtask

  task automatic test_en_and_reset();
    int a, first; logic [1:0] exp;
    a = 0; first = 0;
    launch(3, 0);
    for (int k = 1; k <= 18; k++) begin
      en = !(k >= 2 && k <= 8);
      cfg_valid = (k == 17); cfg_half = CNT_W'(7);
      settle();
      exp = {((a / 3) % 2) == 1, en && (a % 3) == 2};
      total_cnt++;
      if ({clk_out, tick} !== exp) $display("FAIL en_freeze k=%0d: out/tick %b want %b", k, {clk_out, tick}, exp);
      else pass_cnt++;
      if (tick && first == 0) first = k;
      if (k == 18) begin
        total_cnt++;
        if ({cfg_ready, clk_out} !== 2'b01) $display("FAIL en_pend: ready/out %b want 01", {cfg_ready, clk_out});
        else pass_cnt++;
        rst = 1'b1; #1;
        total_cnt++;
        if ({clk_out, busy, cfg_ready} !== 3'b001) $display("FAIL async_reset: out/busy/ready %b want 001", {clk_out, busy, cfg_ready});
        else pass_cnt++;
      end
      if (en) a++;
      if (k < 18) clk_edge();
    end
    cfg_valid = 1'b0; en = 1'b1;
    total_cnt++;
    if (first !== 10) $display("FAIL en_stretch: first tick %0d want 10", first); else pass_cnt++;
    clk_edge();
    rst = 1'b0;
    clk_edge();
    first = 0;
    cfg_burst = BURST_W'(1); start = 1'b1;
    clk_edge();
    start = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      settle();
      if (tick && first == 0) first = k;
      clk_edge();
    end
    total_cnt++;
    if (first !== DEF_HALF) $display("FAIL reset_pend_cleared: first tick %0d want %0d", first, DEF_HALF);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int h, n, hh, a, end_a, k;
      bit ebusy, park, stopped, lvl, etick, edone;
      logic [4:0] exp;
      h = $urandom_range(0, 6); n = $urandom_range(0, 3);
      hh = (h == 0) ? 1 : h;
      launch(h, n);
      a = 0; ebusy = 1'b1; park = 1'b0; stopped = 1'b0;
      end_a = (n == 0) ? 1_000_000 : 2 * hh * n;
      for (k = 0; k < 300 && ebusy; k++) begin
        en    = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 9) == 0);
        stop  = (k > 40) || ($urandom_range(0, 29) == 0);
        settle();
        lvl   = !park && ((a / hh) % 2) == 1;
        etick = en && (a % hh) == hh - 1;
        edone = etick && !stopped && n != 0 && (a + 1) == 2 * hh * n;
        exp = {lvl, etick, edone, 1'b1, 1'b1};
        total_cnt++;
        if ({clk_out, tick, done, busy, cfg_ready} !== exp)
          $display("FAIL rand it=%0d k=%0d h=%0d n=%0d: out/tick/done/busy/ready %b want %b", it, k, hh, n, {clk_out, tick, done, busy, cfg_ready}, exp);
        else pass_cnt++;
        if (park) ebusy = 1'b0;
        else begin
          if (stop && !stopped && !edone) begin
            stopped = 1'b1;
            if (lvl || etick) begin
              if ((a / (2 * hh) + 1) * 2 * hh < end_a) end_a = (a / (2 * hh) + 1) * 2 * hh;
            end else park = 1'b1;
          end
          if (en) a++;
          if (!park && a >= end_a) ebusy = 1'b0;
        end
        clk_edge();
      end
      start = 1'b0; stop = 1'b0; en = 1'b1;
      settle();
      total_cnt++;
      if (ebusy || {busy, clk_out} !== 2'b00) $display("FAIL rand_end it=%0d: busy/out %b model_busy %b want 00 0", it, {busy, clk_out}, ebusy);
      else pass_cnt++;
      clk_edge();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_continuous();
    test_burst();
    test_cfg_mid();
    test_stop();
    test_en_and_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
